// File: rtl/rec_pkg.sv
// rec_pkg: definitions shared by the record, playback and controller blocks.
package rec_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PAUSE  = 2'd2,
        FLUSH  = 2'd3
    } rec_state_t;

endpackage

// File: rtl/rec_if.sv
// rec_if: audio sink handshake plus SDRAM arbiter write port of the record engine.
// The master modport is the record engine's view; slave is the environment's view.
interface rec_if;
    import rec_pkg::*;

    logic              rec_write;
    logic [ADDR_W-1:0] rec_addr;
    logic [DATA_W-1:0] rec_writedata;
    logic              rec_sdram_finished;
    logic              rec_audio_valid;
    logic [DATA_W-1:0] rec_audio_data;
    logic              rec_audio_ready;

    modport master (
        output rec_write, rec_addr, rec_writedata, rec_audio_ready,
        input  rec_sdram_finished, rec_audio_valid, rec_audio_data
    );

    modport slave (
        input  rec_write, rec_addr, rec_writedata, rec_audio_ready,
        output rec_sdram_finished, rec_audio_valid, rec_audio_data
    );

endinterface

// File: rtl/rec_sample_fifo.sv
// rec_sample_fifo: small synchronous sample FIFO with a combinational head.
// Push and pop in the same cycle are allowed even when full.
module rec_sample_fifo
    import rec_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    // Sample storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/record_core.sv
// record_core: audio capture engine. Buffers accepted samples and writes them
// as consecutive SDRAM words from a base address latched at start.
// Optional feature macro RECORD_DROP_CNT_EN: ready ignores FIFO fill, samples
// arriving on a full FIFO are discarded and counted in rec_drop_cnt.
module record_core
    import rec_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WORDS  = 2**22
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              rec_start,
    input  logic [ADDR_W-1:0] rec_select,
    input  logic              rec_pause,
    input  logic              rec_stop,
    output logic              rec_done,
    output logic [ADDR_W-1:0] rec_length,
    output logic [15:0]       rec_drop_cnt,
    rec_if.master             bus
);

    localparam logic [ADDR_W-1:0] MAX_W = ADDR_W'(MAX_WORDS);

    rec_state_t        state_q;
    rec_state_t        state_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] acc_cnt_q;
    logic              start_acc;
    logic              recording;
    logic              at_limit;
    logic              drain_done;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    function automatic logic [ADDR_W-1:0] len_inc(input logic [ADDR_W-1:0] v);
        return (v == MAX_W) ? v : v + ADDR_W'(1);
    endfunction

    assign at_limit   = (acc_cnt_q == MAX_W);
    assign drain_done = fifo_empty & ~bus.rec_write;
    assign fifo_pop   = bus.rec_write & bus.rec_sdram_finished;

    rec_sample_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .clear   (start_acc),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (bus.rec_audio_data),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Controller state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Controller next state; stop and the length limit win over pause.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rec_start) state_d = RECORD;
            RECORD:  if (rec_stop || at_limit) state_d = FLUSH;
                     else if (rec_pause)       state_d = PAUSE;
            PAUSE:   if (rec_stop || at_limit) state_d = FLUSH;
                     else if (!rec_pause)      state_d = RECORD;
            FLUSH:   if (drain_done)           state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Controller outputs; pause is a level, so it blocks intake in its first cycle too.
    always_comb begin
        start_acc = 1'b0;
        recording = 1'b0;
        rec_done  = 1'b0;
        case (state_q)
            IDLE:    start_acc = rec_start;
            RECORD:  recording = ~rec_pause;
            FLUSH:   rec_done  = drain_done;
            default: ;
        endcase
    end

`ifdef RECORD_DROP_CNT_EN
    logic fifo_drop;

    function automatic logic [15:0] drop_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign bus.rec_audio_ready = recording & (acc_cnt_q < MAX_W);
    assign fifo_push = bus.rec_audio_valid & bus.rec_audio_ready & (~fifo_full | fifo_pop);
    assign fifo_drop = bus.rec_audio_valid & bus.rec_audio_ready & fifo_full & ~fifo_pop;

    // Count samples discarded because the FIFO was full.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)          rec_drop_cnt <= '0;
        else if (start_acc) rec_drop_cnt <= '0;
        else if (fifo_drop) rec_drop_cnt <= drop_inc(rec_drop_cnt);
    end
`else
    assign bus.rec_audio_ready = recording & ~fifo_full & (acc_cnt_q < MAX_W);
    assign fifo_push    = bus.rec_audio_valid & bus.rec_audio_ready;
    assign rec_drop_cnt = '0;
`endif

    // Take bookkeeping: base address, accepted and committed word counts.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            base_q     <= '0;
            acc_cnt_q  <= '0;
            rec_length <= '0;
        end else if (start_acc) begin
            base_q     <= rec_select;
            acc_cnt_q  <= '0;
            rec_length <= '0;
        end else begin
            if (fifo_push) acc_cnt_q  <= acc_cnt_q + ADDR_W'(1);
            if (fifo_pop)  rec_length <= len_inc(rec_length);
        end
    end

    // SDRAM writer: registered request, address and data held until finished;
    // the drop after finished guarantees an idle cycle between writes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.rec_write     <= 1'b0;
            bus.rec_addr      <= '0;
            bus.rec_writedata <= '0;
        end else if (fifo_pop) begin
            bus.rec_write <= 1'b0;
        end else if (!bus.rec_write && !fifo_empty && state_q != IDLE) begin
            bus.rec_write     <= 1'b1;
            bus.rec_addr      <= base_q + rec_length;
            bus.rec_writedata <= fifo_head;
        end
    end

endmodule

// File: tb/tb_record_core.sv
// tb_record_core: directed tests of record_core (default depth/limit instance
// plus a MAX_WORDS=4 instance for the limit and address-wrap case).
module tb_record_core;

    logic        clk;
    logic        rst;
    logic        start;
    logic        pause;
    logic        stop;
    logic [22:0] sel;
    logic        done_a, done_l;
    logic [22:0] len_a, len_l;
    logic [15:0] drop_a, drop_l;
    int          checks;
    int          errors;

    rec_if if_a ();
    rec_if if_b ();

    record_core #(.FIFO_DEPTH(4)) dut (
        .i_clk(clk), .i_rst(rst), .rec_start(start), .rec_select(sel),
        .rec_pause(pause), .rec_stop(stop), .rec_done(done_a),
        .rec_length(len_a), .rec_drop_cnt(drop_a), .bus(if_a)
    );

    record_core #(.FIFO_DEPTH(4), .MAX_WORDS(4)) dut_l (
        .i_clk(clk), .i_rst(rst), .rec_start(start), .rec_select(sel),
        .rec_pause(pause), .rec_stop(stop), .rec_done(done_l),
        .rec_length(len_l), .rec_drop_cnt(drop_l), .bus(if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [22:0] s);
        sel = s; start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic push_a(input logic [31:0] d, output bit ok);
        ok = 1'b0;
        if_a.rec_audio_valid = 1'b1;
        if_a.rec_audio_data  = d;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (if_a.rec_audio_ready) ok = 1'b1;
            tick();
        end
        if_a.rec_audio_valid = 1'b0;
    endtask

    task automatic serve_a(output logic [22:0] a, output logic [31:0] d, output bit ok);
        ok = 1'b0; a = '0; d = '0;
        for (int c = 0; c < 30 && !ok; c++) begin
            @(negedge clk);
            if (if_a.rec_write) begin
                ok = 1'b1; a = if_a.rec_addr; d = if_a.rec_writedata;
            end else begin
                tick();
            end
        end
        if (ok) begin
            tick(); tick();
            if_a.rec_sdram_finished = 1'b1;
            tick();
            if_a.rec_sdram_finished = 1'b0;
        end
    endtask

    task automatic count_done_a(output int n);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_a) n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        checks++;
        if ({if_a.rec_write, if_a.rec_addr, if_a.rec_writedata, if_a.rec_audio_ready,
             done_a, len_a, drop_a} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: write=%b addr=%h data=%h ready=%b done=%b len=%h drop=%h, required all 0",
                     if_a.rec_write, if_a.rec_addr, if_a.rec_writedata, if_a.rec_audio_ready, done_a, len_a, drop_a);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] exp_d [3];
        logic [22:0] a;
        logic [31:0] d;
        bit ok0, ok1, ok2, ok;
        int n;
        exp_d = '{32'hA, 32'hB, 32'hC};
        pulse_start(23'h100);
        push_a(32'hA, ok0); push_a(32'hB, ok1); push_a(32'hC, ok2);
        checks++;
        if (!(ok0 && ok1 && ok2)) begin
            errors++; $display("FAIL basic_accept: accepted %b%b%b, required 111", ok0, ok1, ok2);
        end
        for (int i = 0; i < 3; i++) begin
            serve_a(a, d, ok);
            checks++;
            if (!ok || a !== 23'h100 + 23'(i) || d !== exp_d[i]) begin
                errors++;
                $display("FAIL basic_write%0d: ok=%b addr=%h data=%h, required addr=%h data=%h",
                         i, ok, a, d, 23'h100 + 23'(i), exp_d[i]);
            end
        end
        pulse_stop();
        count_done_a(n);
        checks++;
        if (n != 1) begin errors++; $display("FAIL basic_done: %0d pulses, required 1", n); end
        checks++;
        if (len_a !== 23'd3) begin errors++; $display("FAIL basic_length: %h, required 3", len_a); end
    endtask

    task automatic test_back_pressure();
        int idx;
        bit acc, ok;
        int n;
        logic [22:0] a;
        logic [31:0] d;
        pulse_start(23'h200);
        idx = 0;
        if_a.rec_audio_valid = 1'b1;
        if_a.rec_audio_data  = 32'h10;
        repeat (12) begin
            @(negedge clk);
            acc = if_a.rec_audio_ready;
            tick();
            if (acc) begin idx++; if_a.rec_audio_data = 32'h10 + 32'(idx); end
        end
        @(negedge clk);
        checks++;
        if (idx != 4 || if_a.rec_audio_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accept: accepted %0d ready=%b, required 4 and 0", idx, if_a.rec_audio_ready);
        end
        if_a.rec_audio_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            serve_a(a, d, ok);
            checks++;
            if (!ok || a !== 23'h200 + 23'(i) || d !== 32'h10 + 32'(i)) begin
                errors++;
                $display("FAIL bp_write%0d: ok=%b addr=%h data=%h, required addr=%h data=%h",
                         i, ok, a, d, 23'h200 + 23'(i), 32'h10 + 32'(i));
            end
        end
        pulse_stop();
        count_done_a(n);
        checks++;
        if (n != 1 || len_a !== 23'd4) begin
            errors++; $display("FAIL bp_done: pulses=%0d len=%h, required 1 and 4", n, len_a);
        end
    endtask

    task automatic test_pause();
        logic [22:0] la [8];
        logic [31:0] ld [8];
        int nl, rdy, n;
        bit ok0, ok1;
        nl = 0; rdy = 0;
        pulse_start(23'h300);
        push_a(32'h20, ok0); push_a(32'h21, ok1);
        pause = 1'b1;
        if_a.rec_audio_valid = 1'b1;
        if_a.rec_audio_data  = 32'h99;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (if_a.rec_audio_ready) rdy++;
            if (if_a.rec_write && nl < 8) begin
                la[nl] = if_a.rec_addr; ld[nl] = if_a.rec_writedata; nl++;
                if_a.rec_sdram_finished = 1'b1;
            end
            @(posedge clk);
            #1;
            if_a.rec_sdram_finished = 1'b0;
        end
        checks++;
        if (!(ok0 && ok1) || rdy != 0) begin
            errors++; $display("FAIL pause_ready: pushes=%b%b ready cycles=%0d, required 11 and 0", ok0, ok1, rdy);
        end
        checks++;
        if (nl != 2 || la[0] !== 23'h300 || ld[0] !== 32'h20 || la[1] !== 23'h301 || ld[1] !== 32'h21) begin
            errors++;
            $display("FAIL pause_drain: writes=%0d (%h,%h) (%h,%h), required 2 (300,20) (301,21)",
                     nl, la[0], ld[0], la[1], ld[1]);
        end
        checks++;
        if (len_a !== 23'd2) begin errors++; $display("FAIL pause_length: %h, required 2", len_a); end
        pause = 1'b0;
        if_a.rec_audio_valid = 1'b0;
        pulse_stop();
        count_done_a(n);
        checks++;
        if (n != 1 || len_a !== 23'd2) begin
            errors++; $display("FAIL pause_done: pulses=%0d len=%h, required 1 and 2", n, len_a);
        end
    endtask

    task automatic test_ignores();
        logic [22:0] a;
        logic [31:0] d;
        bit ok, okp;
        int n;
        pulse_start(23'h400);
        pulse_start(23'h555);
        push_a(32'h30, okp);
        serve_a(a, d, ok);
        checks++;
        if (!okp || !ok || a !== 23'h400 || d !== 32'h30) begin
            errors++; $display("FAIL ign_start: addr=%h data=%h, required 400 and 30", a, d);
        end
        pulse_stop();
        count_done_a(n);
        pulse_stop();
        count_done_a(n);
        checks++;
        if (n != 0) begin errors++; $display("FAIL ign_stop_idle: %0d done pulses, required 0", n); end
    endtask

    task automatic test_reset_mid();
        logic [22:0] a;
        logic [31:0] d;
        bit ok, ok0, ok1, seen;
        int n;
        pulse_start(23'h500);
        push_a(32'h40, ok0); push_a(32'h41, ok1);
        serve_a(a, d, ok);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (if_a.rec_write) seen = 1'b1; else tick();
        end
        rst = 1'b1;
        #1;
        checks++;
        if (!seen || len_a !== '0 || if_a.rec_write !== 1'b0 || if_a.rec_addr !== '0 ||
            if_a.rec_writedata !== '0 || if_a.rec_audio_ready !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: seen=%b len=%h write=%b addr=%h data=%h ready=%b done=%b, required write seen and all 0",
                     seen, len_a, if_a.rec_write, if_a.rec_addr, if_a.rec_writedata, if_a.rec_audio_ready, done_a);
        end
        tick();
        rst = 1'b0;
        tick();
        if_a.rec_audio_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (if_a.rec_audio_ready !== 1'b0) begin
            errors++; $display("FAIL idle_ready: ready=%b, required 0", if_a.rec_audio_ready);
        end
        tick();
        pulse_start(23'h600);
        push_a(32'h42, ok);
        serve_a(a, d, ok);
        checks++;
        if (!ok || a !== 23'h600 || d !== 32'h42) begin
            errors++; $display("FAIL rst_discard: addr=%h data=%h, required 600 and 42", a, d);
        end
        pulse_stop();
        count_done_a(n);
    endtask

    task automatic test_limit_wrap();
        logic [22:0] la [8];
        logic [31:0] ld [8];
        logic [22:0] ea [4];
        int idx, nl, dn;
        bit acc;
        ea = '{23'h7FFFFE, 23'h7FFFFF, 23'h000000, 23'h000001};
        idx = 0; nl = 0; dn = 0;
        pulse_start(23'h7FFFFE);
        if_b.rec_audio_valid = 1'b1;
        if_b.rec_audio_data  = 32'h50;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_l) dn++;
            acc = if_b.rec_audio_ready & if_b.rec_audio_valid;
            if (if_b.rec_write && nl < 8) begin
                la[nl] = if_b.rec_addr; ld[nl] = if_b.rec_writedata; nl++;
                if_b.rec_sdram_finished = 1'b1;
            end
            @(posedge clk);
            #1;
            if_b.rec_sdram_finished = 1'b0;
            if (acc) begin
                idx++;
                if (idx < 6) if_b.rec_audio_data = 32'h50 + 32'(idx);
                else         if_b.rec_audio_valid = 1'b0;
            end
        end
        if_b.rec_audio_valid = 1'b0;
        checks++;
        if (idx != 4 || nl != 4) begin
            errors++; $display("FAIL lim_accept: accepted=%0d writes=%0d, required 4 and 4", idx, nl);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (la[i] !== ea[i] || ld[i] !== 32'h50 + 32'(i)) begin
                errors++;
                $display("FAIL lim_write%0d: addr=%h data=%h, required addr=%h data=%h",
                         i, la[i], ld[i], ea[i], 32'h50 + 32'(i));
            end
        end
        checks++;
        if (dn != 1 || len_l !== 23'd4) begin
            errors++; $display("FAIL lim_done: pulses=%0d len=%h, required 1 and 4", dn, len_l);
        end
        pulse_stop();
        tick(); tick();
    endtask

    task automatic test_drop();
        int idx, rdy, n;
        bit acc, ok;
        logic [22:0] a;
        logic [31:0] d;
        idx = 0; rdy = 0;
        pulse_start(23'h700);
        if_a.rec_audio_valid = 1'b1;
        if_a.rec_audio_data  = 32'h60;
        repeat (7) begin
            @(negedge clk);
            if (if_a.rec_audio_ready) rdy++;
            acc = if_a.rec_audio_ready;
            tick();
            if (acc) begin idx++; if_a.rec_audio_data = 32'h60 + 32'(idx); end
        end
        if_a.rec_audio_valid = 1'b0;
`ifdef RECORD_DROP_CNT_EN
        checks++;
        if (rdy != 7 || drop_a !== 16'd3) begin
            errors++; $display("FAIL drop_count: ready cycles=%0d drop=%0d, required 7 and 3", rdy, drop_a);
        end
`else
        checks++;
        if (idx != 4 || drop_a !== 16'd0) begin
            errors++; $display("FAIL drop_off: accepted=%0d drop=%0d, required 4 and 0", idx, drop_a);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            serve_a(a, d, ok);
            checks++;
            if (!ok || a !== 23'h700 + 23'(i) || d !== 32'h60 + 32'(i)) begin
                errors++;
                $display("FAIL drop_write%0d: ok=%b addr=%h data=%h, required addr=%h data=%h",
                         i, ok, a, d, 23'h700 + 23'(i), 32'h60 + 32'(i));
            end
        end
        pulse_stop();
        count_done_a(n);
        checks++;
        if (n != 1 || len_a !== 23'd4) begin
            errors++; $display("FAIL drop_done: pulses=%0d len=%h, required 1 and 4", n, len_a);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; sel = '0;
        if_a.rec_sdram_finished = 1'b0; if_a.rec_audio_valid = 1'b0; if_a.rec_audio_data = '0;
        if_b.rec_sdram_finished = 1'b0; if_b.rec_audio_valid = 1'b0; if_b.rec_audio_data = '0;
        test_reset();
        test_basic();
        test_back_pressure();
        test_pause();
        test_ignores();
        test_reset_mid();
        test_limit_wrap();
        test_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
